// File: rtl/ahb_dual_master_arbiter.sv
// Shares one AHB-lite master port between the scalar core and the vector LSU.
// Address- and data-phase owners are tracked separately so hand-offs respect AHB pipelining.
module ahb_dual_master_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  s_req_i,
  input  logic                  s_trans_i,
  input  logic [DATA_WIDTH-1:0] s_haddr_i,
  input  logic [DATA_WIDTH-1:0] s_hwdata_i,
  input  logic [2:0]            s_hsize_i,
  input  logic                  s_hwrite_i,
  output logic                  s_grant_o,
  output logic                  s_hready_o,
  output logic [1:0]            s_hresp_o,
  input  logic                  v_req_i,
  input  logic                  v_lock_i,
  input  logic                  v_trans_i,
  input  logic [DATA_WIDTH-1:0] v_haddr_i,
  input  logic [DATA_WIDTH-1:0] v_hwdata_i,
  input  logic [2:0]            v_hsize_i,
  input  logic                  v_hwrite_i,
  output logic                  v_grant_o,
  output logic                  v_hready_o,
  output logic [1:0]            v_hresp_o,
  output logic [DATA_WIDTH-1:0] haddr_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  output logic [2:0]            hsize_o,
  output logic                  hwrite_o,
  output logic                  htrans_o,
  input  logic                  hready_i,
  input  logic [1:0]            hresp_i,
  output logic                  addr_owner_o,
  output logic                  data_owner_o
);

  typedef enum logic [1:0] {S_OWN, S_DRAIN, V_OWN, V_DRAIN} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           state;
  logic             addr_owner;
  logic             data_owner;
  logic             data_valid;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_next;
  logic             owner_trans;
  logic             other_req;
  logic             hold_hit;
  logic             s_yield;
  logic             v_yield;
  logic             handoff;

  assign owner_trans = addr_owner ? v_trans_i : s_trans_i;
  assign htrans_o    = ~reset_i & owner_trans;
  assign haddr_o     = addr_owner ? v_haddr_i  : s_haddr_i;
  assign hsize_o     = addr_owner ? v_hsize_i  : s_hsize_i;
  assign hwrite_o    = addr_owner ? v_hwrite_i : s_hwrite_i;
  assign hwdata_o    = data_owner ? v_hwdata_i : s_hwdata_i;

  assign s_hready_o  = hready_i & (~addr_owner | (data_valid & ~data_owner));
  assign v_hready_o  = hready_i & ( addr_owner | (data_valid &  data_owner));
  assign s_hresp_o   = data_owner ? 2'b00 : hresp_i;
  assign v_hresp_o   = data_owner ? hresp_i : 2'b00;

  assign addr_owner_o = addr_owner;
  assign data_owner_o = data_owner;

  // Count is evaluated on its post-edge value so the owner yields right as its last allowed phase is accepted.
  assign other_req = addr_owner ? s_req_i : v_req_i;
  assign hold_next = (hready_i & htrans_o & other_req & (hold_cnt != HOLD_MAX))
                     ? hold_cnt + 1'b1 : hold_cnt;
  assign hold_hit  = (hold_next == HOLD_MAX);

  // A vector lock pre-empts the scalar unconditionally and shields the vector from the hold limit.
  assign s_yield = v_req_i & (~s_req_i | hold_hit | v_lock_i);
  assign v_yield = s_req_i & ~v_lock_i & (~v_req_i | hold_hit);
  assign handoff = hready_i & ~owner_trans;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= S_OWN;
      addr_owner <= 1'b0;
      data_owner <= 1'b0;
      data_valid <= 1'b0;
      hold_cnt   <= '0;
      s_grant_o  <= 1'b1;
      v_grant_o  <= 1'b0;
    end else begin
      if (hready_i) begin
        data_owner <= addr_owner;
        data_valid <= htrans_o;
      end
      hold_cnt <= hold_next;
      case (state)
        S_OWN: begin
          if (s_yield) begin
            state     <= S_DRAIN;
            s_grant_o <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (handoff) begin
            state      <= V_OWN;
            addr_owner <= 1'b1;
            v_grant_o  <= 1'b1;
            hold_cnt   <= '0;
          end
        end
        V_OWN: begin
          if (v_yield) begin
            state     <= V_DRAIN;
            v_grant_o <= 1'b0;
          end
        end
        V_DRAIN: begin
          if (handoff) begin
            state      <= S_OWN;
            addr_owner <= 1'b0;
            s_grant_o  <= 1'b1;
            hold_cnt   <= '0;
          end
        end
        default: begin
          state      <= S_OWN;
          addr_owner <= 1'b0;
          s_grant_o  <= 1'b1;
          v_grant_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_dual_master_arbiter.sv
// Bench for ahb_dual_master_arbiter: directed vector table, corner-case sequences and
// randomized cycles compared against an ownership-level reference model.
module tb_ahb_dual_master_arbiter;

  localparam int DW = 32;
  localparam int MH = 16;
  localparam int CW = 5;
  localparam int OW = 79;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          s_req_i, s_trans_i, s_hwrite_i;
  logic [DW-1:0] s_haddr_i, s_hwdata_i;
  logic [2:0]    s_hsize_i;
  logic          s_grant_o, s_hready_o;
  logic [1:0]    s_hresp_o;
  logic          v_req_i, v_lock_i, v_trans_i, v_hwrite_i;
  logic [DW-1:0] v_haddr_i, v_hwdata_i;
  logic [2:0]    v_hsize_i;
  logic          v_grant_o, v_hready_o;
  logic [1:0]    v_hresp_o;
  logic [DW-1:0] haddr_o, hwdata_o;
  logic [2:0]    hsize_o;
  logic          hwrite_o, htrans_o;
  logic          hready_i;
  logic [1:0]    hresp_i;
  logic          addr_owner_o, data_owner_o;

  always #5 clk_i = ~clk_i;

  ahb_dual_master_arbiter #(.DATA_WIDTH(DW), .MAX_HOLD(MH), .CNT_W(CW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .s_req_i(s_req_i), .s_trans_i(s_trans_i), .s_haddr_i(s_haddr_i), .s_hwdata_i(s_hwdata_i),
    .s_hsize_i(s_hsize_i), .s_hwrite_i(s_hwrite_i), .s_grant_o(s_grant_o),
    .s_hready_o(s_hready_o), .s_hresp_o(s_hresp_o),
    .v_req_i(v_req_i), .v_lock_i(v_lock_i), .v_trans_i(v_trans_i), .v_haddr_i(v_haddr_i),
    .v_hwdata_i(v_hwdata_i), .v_hsize_i(v_hsize_i), .v_hwrite_i(v_hwrite_i),
    .v_grant_o(v_grant_o), .v_hready_o(v_hready_o), .v_hresp_o(v_hresp_o),
    .haddr_o(haddr_o), .hwdata_o(hwdata_o), .hsize_o(hsize_o), .hwrite_o(hwrite_o),
    .htrans_o(htrans_o), .hready_i(hready_i), .hresp_i(hresp_i),
    .addr_owner_o(addr_owner_o), .data_owner_o(data_owner_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] dut_outs();
    return {s_grant_o, v_grant_o, addr_owner_o, data_owner_o, htrans_o, haddr_o, hwdata_o,
            hsize_o, hwrite_o, s_hready_o, v_hready_o, s_hresp_o, v_hresp_o};
  endfunction

  // Reference model: who owns the address bus, whether a hand-off is pending,
  // how many phases the owner has had accepted while contested, and who owns the data phase.
  int m_owner, m_downer, m_hold;
  bit m_drain, m_dvalid;

  task automatic model_reset();
    m_owner = 0; m_downer = 0; m_hold = 0; m_drain = 0; m_dvalid = 0;
  endtask

  function automatic bit m_trans();
    if (reset_i) return 1'b0;
    return (m_owner == 1) ? v_trans_i : s_trans_i;
  endfunction

  function automatic logic [OW-1:0] model_outs();
    logic          sg, vg, sh, vh;
    logic [DW-1:0] ha, hw;
    logic [2:0]    hs;
    logic          hwr;
    logic [1:0]    sr, vr;
    sg  = (m_owner == 0) && !m_drain;
    vg  = (m_owner == 1) && !m_drain;
    ha  = (m_owner == 1) ? v_haddr_i  : s_haddr_i;
    hs  = (m_owner == 1) ? v_hsize_i  : s_hsize_i;
    hwr = (m_owner == 1) ? v_hwrite_i : s_hwrite_i;
    hw  = (m_downer == 1) ? v_hwdata_i : s_hwdata_i;
    sh  = hready_i && ((m_owner == 0) || (m_dvalid && m_downer == 0));
    vh  = hready_i && ((m_owner == 1) || (m_dvalid && m_downer == 1));
    sr  = (m_downer == 0) ? hresp_i : 2'b00;
    vr  = (m_downer == 1) ? hresp_i : 2'b00;
    return {sg, vg, (m_owner == 1), (m_downer == 1), m_trans(), ha, hw, hs, hwr, sh, vh, sr, vr};
  endfunction

  task automatic model_step();
    bit acc, oreq, oown_req, otrans, yield;
    int cnt, old_owner;
    if (reset_i) begin
      model_reset();
      return;
    end
    old_owner = m_owner;
    acc      = hready_i && m_trans();
    oreq     = (m_owner == 1) ? s_req_i : v_req_i;
    oown_req = (m_owner == 1) ? v_req_i : s_req_i;
    otrans   = (m_owner == 1) ? v_trans_i : s_trans_i;
    cnt = m_hold + ((acc && oreq) ? 1 : 0);
    if (cnt > MH) cnt = MH;
    if (!m_drain) begin
      if (m_owner == 0) yield = v_req_i && (!oown_req || cnt == MH || v_lock_i);
      else              yield = s_req_i && !v_lock_i && (!oown_req || cnt == MH);
      m_drain = yield;
      m_hold  = cnt;
    end else if (hready_i && !otrans) begin
      m_owner = 1 - m_owner;
      m_drain = 0;
      m_hold  = 0;
    end else begin
      m_hold = cnt;
    end
    if (hready_i) begin
      m_downer = old_owner;
      m_dvalid = acc;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    s_req_i = 0; s_trans_i = 0; v_req_i = 0; v_lock_i = 0; v_trans_i = 0;
    hready_i = 1; hresp_i = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1;
    tick();
    tick();
    reset_i = 0;
    model_reset();
  endtask

  typedef struct {
    logic sr, st, vr, vl, vt, hr;
    logic [1:0] resp;
    logic sg, vg, ao, dow, ht;
    logic [DW-1:0] ha, hw;
    logic shr, vhr;
    logic [1:0] sresp, vresp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int  acc, got, bad, vacc;
    logic [OW-1:0] exp_v;

    tbl[0] = '{1,1,0,0,0,1,2'b00, 1,0,0,0,1, 32'h100, 32'hAAAA, 1,0, 2'b00,2'b00};
    tbl[1] = '{1,0,0,0,0,1,2'b01, 1,0,0,0,0, 32'h100, 32'hAAAA, 1,0, 2'b01,2'b00};
    tbl[2] = '{0,0,1,0,0,1,2'b00, 1,0,0,0,0, 32'h100, 32'hAAAA, 1,0, 2'b00,2'b00};
    tbl[3] = '{0,0,1,0,0,1,2'b00, 0,0,0,0,0, 32'h100, 32'hAAAA, 1,0, 2'b00,2'b00};
    tbl[4] = '{1,0,0,0,1,1,2'b00, 0,1,1,0,1, 32'h200, 32'hAAAA, 0,1, 2'b00,2'b00};
    tbl[5] = '{1,0,0,0,0,1,2'b10, 0,0,1,1,0, 32'h200, 32'hBBBB, 0,1, 2'b00,2'b10};
    tbl[6] = '{1,1,0,0,0,1,2'b00, 1,0,0,1,1, 32'h100, 32'hBBBB, 1,0, 2'b00,2'b00};
    tbl[7] = '{1,1,0,0,0,0,2'b00, 1,0,0,0,1, 32'h100, 32'hAAAA, 0,0, 2'b00,2'b00};
    tbl[8] = '{1,1,0,0,0,1,2'b11, 1,0,0,0,1, 32'h100, 32'hAAAA, 1,0, 2'b11,2'b00};

    s_haddr_i = 32'h100; s_hwdata_i = 32'hAAAA; s_hsize_i = 3'd2; s_hwrite_i = 1'b0;
    v_haddr_i = 32'h200; v_hwdata_i = 32'hBBBB; v_hsize_i = 3'd3; v_hwrite_i = 1'b1;
    idle_inputs();

    // Reset state, with scalar trans asserted during reset to show it is gated.
    reset_i = 1; s_trans_i = 1;
    tick();
    check_int("reset_s_grant", int'(s_grant_o), 1);
    check_int("reset_v_grant", int'(v_grant_o), 0);
    check_int("reset_owners", int'({addr_owner_o, data_owner_o}), 0);
    check_int("reset_htrans_gated", int'(htrans_o), 0);
    tick();
    reset_i = 0;
    idle_inputs();

    for (int i = 0; i < 9; i++) begin
      s_req_i = tbl[i].sr; s_trans_i = tbl[i].st; v_req_i = tbl[i].vr;
      v_lock_i = tbl[i].vl; v_trans_i = tbl[i].vt; hready_i = tbl[i].hr; hresp_i = tbl[i].resp;
      @(negedge clk_i);
      n_tests++;
      if ({s_grant_o, v_grant_o, addr_owner_o, data_owner_o, htrans_o, haddr_o, hwdata_o,
           s_hready_o, v_hready_o, s_hresp_o, v_hresp_o} !==
          {tbl[i].sg, tbl[i].vg, tbl[i].ao, tbl[i].dow, tbl[i].ht, tbl[i].ha, tbl[i].hw,
           tbl[i].shr, tbl[i].vhr, tbl[i].sresp, tbl[i].vresp}) begin
        n_fail++;
        $display("FAIL vec%0d: got g=%b%b own=%b%b ht=%b a=%h d=%h rdy=%b%b resp=%b/%b expected g=%b%b own=%b%b ht=%b a=%h d=%h rdy=%b%b resp=%b/%b",
                 i, s_grant_o, v_grant_o, addr_owner_o, data_owner_o, htrans_o, haddr_o, hwdata_o,
                 s_hready_o, v_hready_o, s_hresp_o, v_hresp_o,
                 tbl[i].sg, tbl[i].vg, tbl[i].ao, tbl[i].dow, tbl[i].ht, tbl[i].ha, tbl[i].hw,
                 tbl[i].shr, tbl[i].vhr, tbl[i].sresp, tbl[i].vresp);
      end
      tick();
    end

    // Hold limit: scalar streams while the vector waits without a lock.
    do_reset();
    s_req_i = 1; v_req_i = 1; acc = 0; got = 0;
    for (int c = 0; c < 100 && got == 0; c++) begin
      s_trans_i = s_grant_o;
      @(negedge clk_i);
      if (hready_i && htrans_o && !addr_owner_o) acc++;
      tick();
      if (v_grant_o) got = 1;
    end
    check_int("hold_limit_accepts", acc, MH);
    check_int("hold_limit_vgrant", got, 1);
    check_int("hold_limit_owner", int'(addr_owner_o), 1);

    // Vector lock holds the scalar off well beyond the hold limit.
    do_reset();
    s_req_i = 1; v_req_i = 1; v_lock_i = 1; vacc = 0; bad = 0;
    for (int c = 0; c < 200 && vacc < 40; c++) begin
      s_trans_i = s_grant_o;
      v_trans_i = v_grant_o;
      @(negedge clk_i);
      if (hready_i && htrans_o && addr_owner_o) vacc++;
      if (addr_owner_o && s_grant_o) bad++;
      tick();
    end
    check_int("lock_vector_phases", vacc, 40);
    check_int("lock_no_scalar_grant", bad, 0);
    check_int("lock_owner_kept", int'(addr_owner_o), 1);
    v_req_i = 0; v_lock_i = 0; v_trans_i = 0; got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      s_trans_i = 0;
      tick();
      if (s_grant_o) got = 1;
    end
    check_int("unlock_scalar_grant", got, 1);

    // Wait states in DRAIN with owner trans high, then reset pulse while draining.
    do_reset();
    s_req_i = 0; s_trans_i = 1; v_req_i = 1;
    tick();
    check_int("drain_enter", int'({s_grant_o, v_grant_o, addr_owner_o}), 0);
    hready_i = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_int($sformatf("drain_wait%0d", c), int'({v_grant_o, addr_owner_o}), 0);
    end
    hready_i = 1;
    tick();
    check_int("drain_trans_still_high", int'({v_grant_o, addr_owner_o}), 0);
    s_trans_i = 0;
    tick();
    check_int("drain_handoff", int'({v_grant_o, addr_owner_o}), 3);
    s_req_i = 1; v_req_i = 0; v_trans_i = 0;
    tick();
    check_int("vdrain_enter", int'({s_grant_o, v_grant_o, addr_owner_o}), 1);
    reset_i = 1; v_trans_i = 1;
    @(negedge clk_i);
    check_int("reset_gates_htrans", int'(htrans_o), 0);
    tick();
    check_int("reset_in_drain", int'({s_grant_o, v_grant_o, addr_owner_o, data_owner_o}), 8);
    reset_i = 0;

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset_i    = ($urandom_range(0, 59) == 0);
      s_req_i    = 1'($urandom_range(0, 1));
      s_trans_i  = 1'($urandom_range(0, 1));
      v_req_i    = 1'($urandom_range(0, 1));
      v_lock_i   = ($urandom_range(0, 3) == 0);
      v_trans_i  = 1'($urandom_range(0, 1));
      hready_i   = ($urandom_range(0, 3) != 0);
      hresp_i    = 2'($urandom_range(0, 3));
      s_haddr_i  = $urandom(); s_hwdata_i = $urandom();
      v_haddr_i  = $urandom(); v_hwdata_i = $urandom();
      s_hsize_i  = 3'($urandom_range(0, 7)); v_hsize_i = 3'($urandom_range(0, 7));
      s_hwrite_i = 1'($urandom_range(0, 1)); v_hwrite_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      exp_v = model_outs();
      check_vec($sformatf("rand%0d", c), dut_outs(), exp_v);
      @(posedge clk_i);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
